// File: rtl/fifo_clase_fwft_pkg.sv
// Shared constants and class encodings for the class FIFO, the class arbiter
// and the per-class downstream FIFOs.
package fifo_clase_fwft_pkg;

  localparam int DATA_W        = 12;
  localparam int CLASS_HI      = 11;
  localparam int CLASS_LO      = 10;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_PTR_W     = 3;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 1;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    CLS_0 = 2'd0,
    CLS_1 = 2'd1,
    CLS_2 = 2'd2,
    CLS_3 = 2'd3
  } class_e;

  function automatic class_e class_of(input word_t w);
    logic [1:0] cls;
    cls = w[CLASS_HI:CLASS_LO];
    return class_e'(cls);
  endfunction

endpackage

// File: rtl/fifo_clase_fwft_if.sv
// Producer/consumer side of the class FIFO; master drives push/pop, slave is the FIFO.
interface fifo_clase_fwft_if #(
  parameter int DW = fifo_clase_fwft_pkg::DATA_W,
  parameter int PW = fifo_clase_fwft_pkg::DEF_PTR_W
);

  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [PW:0]   count;
  logic          err_overflow;
  logic          err_underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, empty, full, almost_full, almost_empty, count,
           err_overflow, err_underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, empty, full, almost_full, almost_empty, count,
           err_overflow, err_underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// Register-array storage: one synchronous write port, one asynchronous read port
// so the FIFO head is visible in the same cycle it is addressed.
module fifo_mem_2p #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Contents are never reset; pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fifo_clase_fwft.sv
// First-word-fall-through FIFO feeding the class arbiter: head word is driven
// combinationally from storage so the arbiter can inspect and pop in one cycle.
module fifo_clase_fwft
  import fifo_clase_fwft_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_W     = DEF_PTR_W,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             reset,
  fifo_clase_fwft_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_ovf_reg, err_ovf_next;
  logic             err_udf_reg, err_udf_next;

  logic  empty;
  logic  full;
  logic  wr_en;
  logic  rd_en;
  word_t rd_data;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_FULL);

  // When full, a simultaneous pop frees the slot the write lands in (wr_ptr == rd_ptr).
  assign wr_en = bus.push & (~full | bus.pop);
  assign rd_en = bus.pop & ~empty;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    err_ovf_next = err_ovf_reg | (bus.push & full & ~bus.pop);
    err_udf_next = err_udf_reg | (bus.pop & empty);

    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      err_ovf_reg <= err_ovf_next;
      err_udf_reg <= err_udf_next;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (bus.data_in),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

  // Flags decode the registered count only, so they never glitch on input changes.
  assign bus.data_out      = empty ? '0 : rd_data;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.almost_full   = (count_reg >= CNT_AF);
  assign bus.almost_empty  = (count_reg <= CNT_AE);
  assign bus.count         = count_reg;
  assign bus.err_overflow  = err_ovf_reg;
  assign bus.err_underflow = err_udf_reg;

endmodule
